uart_rx_word: RTL and testbench
===============================

Name: uart_rx_word

Overview:
8N1 UART receiver that deserialises the serial `rx` line into bytes and packs them, least-significant byte first, into WIDTH-bit words.
Each completed word is presented on `data_out` with a one-cycle `write` pulse. The block sits directly upstream of the receive FIFO: `data_out`/`write` connect straight to the FIFO's `data_in`/`write`.
Framing errors drop the partial word so the FIFO only ever receives whole words.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
WIDTH, 32, output word width; must be a multiple of 8. BYTES = WIDTH/8.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
clear  input  1  synchronous; discards any partially assembled word
write  output  1  one-cycle pulse, data_out holds a complete word
data_out  output  WIDTH  last completed word, byte 0 in [7:0]
byte_valid  output  1  one-cycle pulse per good received byte
byte_data  output  8  last good received byte
frame_err  output  1  one-cycle pulse when the stop bit samples 0
byte_idx  output  $clog2(BYTES)  number of bytes already held in the current partial word

Behaviour:
- Reset (async, active-high): all outputs are 0. State = IDLE. Bit, baud and byte counters are 0. Synchroniser flops are 1 (line idle).
- rx passes through a 2-flop synchroniser (rx_s), giving 2 cycles of input latency. All sampling uses rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rx_s==0, go to START with baud_cnt=0.
- START: at baud_cnt == CLKS_PER_BIT/2-1, sample rx_s.
  - If 1: glitch; return to IDLE, no outputs.
  - If 0: go to DATA with baud_cnt=0 and bit_cnt=0.
- DATA: when baud_cnt == CLKS_PER_BIT-1, sample rx_s into shift[bit_cnt] (LSB first), reset baud_cnt, increment bit_cnt. After bit 7 is sampled, go to STOP.
- STOP: at baud_cnt == CLKS_PER_BIT-1, sample rx_s.
  - If 1: next cycle byte_valid=1 and byte_data=shift. The byte is placed in word_buf[8*byte_idx +: 8] and byte_idx increments. Go to IDLE.
  - If 0: next cycle frame_err=1, byte_idx=0 (partial word dropped), byte not stored. Go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line never produces repeated bytes.
- Word completion: when the stored byte is byte BYTES-1, on the same cycle as byte_valid:
  - write=1 and data_out = {new byte, word_buf[8*(BYTES-1)-1:0]}
  - byte_idx wraps to 0.
  - data_out holds until the next completed word.
- write, byte_valid and frame_err are exactly one cycle wide. write never coincides with frame_err.
- Back-to-back frames: a start bit may begin on the cycle after STOP sampling. IDLE detects it with no dead cycle beyond the state transition.
- clear: byte_idx=0 on the next cycle. Does not disturb an in-flight byte; that byte becomes byte 0 of the new word.
  - If clear coincides with a byte completion, the clear wins: the byte is discarded and there is no write.
- Reset mid-frame returns to IDLE immediately. Any partial word is lost.
- No back-pressure: the downstream FIFO accepts every write (it overwrites the oldest entry when full). This block does not stall.

Decomposition:
- Shared package (uart_pkg): state encoding localparams (IDLE/START/DATA/STOP/BREAK) and the default CLKS_PER_BIT, so the future uart_tx uses the same values.
- Natural sub-module: uart_rx_byte (synchroniser + bit FSM; outputs byte pulse, byte, frame_err).
- uart_rx_word instantiates it and adds the byte packer, byte_idx counter and clear logic.

Test Plan (CLKS_PER_BIT=16, WIDTH=32):
- Send bytes EF, BE, AD, DE with 2 idle bits between frames -> four byte_valid pulses; one write pulse coincident with the 4th; data_out=0xDEADBEEF; byte_idx returns to 0.
- rx low for 5 cycles, then high -> no byte_valid, no frame_err; FSM back in IDLE; following frame 0x5A received correctly.
- Send 11, 22, then 0x55 with stop bit=0 and the line held low for 40 cycles, then 11 22 33 44 -> a single frame_err pulse; no write for the first group; then write with data_out=0x44332211.
- Send A1, B2, pulse clear, send 01 02 03 04 -> exactly one write; data_out=0x04030201.
- Assert reset mid-DATA of the 3rd byte, release, send 78 56 34 12 -> all outputs 0 during reset; then a single write with data_out=0x12345678.
- Send 8 bytes 00..07 with zero idle between stop and next start -> writes with 0x03020100 then 0x07060504; no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver state encoding and the
// default bit period. The transmitter uses the same values so both ends of
// the link agree on timing and state numbering.
// ---------------------------------------------------------------------------
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte receiver: 2-flop synchroniser on rx followed by the bit-level FSM.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rx           raw serial line (idle high)
//   byte_done    combinational strobe on the cycle a good stop bit is sampled
//   frame_bad    combinational strobe on the cycle a bad stop bit is sampled
//   shift_byte   assembled byte (valid while byte_done is high)
//   byte_valid   registered one-cycle pulse per good byte
//   byte_data    last good byte
//   frame_err    registered one-cycle pulse per framing error
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_done,
    output logic       frame_bad,
    output logic [7:0] shift_byte,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_s;
    uart_state_t       state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [7:0]        shift, shift_nxt;

    // Synchroniser flops reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            byte_valid <= byte_done;
            frame_err  <= frame_bad;
            if (byte_done) begin
                byte_data <= shift;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    baud_nxt  = '0;
                end
            end
            // Re-check the line half a bit in: a short low pulse is a glitch.
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt           = '0;
                    shift_nxt[bit_cnt] = rx_s;
                    bit_nxt            = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            // A line held low must return high before another start bit counts.
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign shift_byte = shift;

endmodule

// File: rtl/uart_rx_word.sv
// ---------------------------------------------------------------------------
// uart_rx_word
// 8N1 UART receiver that packs bytes LSB-first into WIDTH-bit words for the
// receive FIFO. Framing errors and clear drop the partial word.
// WIDTH must be a multiple of 8 and at least 16.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rx           serial line (idle high)
//   clear        synchronous; discard the partially assembled word
//   write        one-cycle pulse, data_out holds a complete word
//   data_out     last completed word, byte 0 in [7:0]
//   byte_valid   one-cycle pulse per good byte
//   byte_data    last good byte
//   frame_err    one-cycle pulse on a bad stop bit
//   byte_idx     bytes already held in the current partial word
// ---------------------------------------------------------------------------
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         clear,
    output logic                         write,
    output logic [WIDTH-1:0]             data_out,
    output logic                         byte_valid,
    output logic [7:0]                   byte_data,
    output logic                         frame_err,
    output logic [$clog2(WIDTH/8)-1:0]   byte_idx
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    logic             byte_done;
    logic             frame_bad;
    logic [7:0]       shift_byte;
    // The last byte goes straight to data_out, so only BYTES-1 are buffered.
    logic [WIDTH-9:0] word_buf;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_done  (byte_done),
        .frame_bad  (frame_bad),
        .shift_byte (shift_byte),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Packer runs off the pre-registration strobes so write lands on the
    // same cycle as byte_valid. clear takes priority over a completing byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            word_buf <= '0;
            data_out <= '0;
            write    <= 1'b0;
        end else begin
            write <= 1'b0;
            if (clear || frame_bad) begin
                byte_idx <= '0;
            end else if (byte_done) begin
                if (byte_idx == IDX_LAST) begin
                    write    <= 1'b1;
                    data_out <= {shift_byte, word_buf};
                    byte_idx <= '0;
                end else begin
                    word_buf[{byte_idx, 3'b000} +: 8] <= shift_byte;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word
// Directed bench for uart_rx_word with CLKS_PER_BIT=16, WIDTH=32.
// ---------------------------------------------------------------------------
module tb_uart_rx_word;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             rx = 1'b1;
    logic             clear = 1'b0;
    logic             write;
    logic [WIDTH-1:0] data_out;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;
    logic [1:0]       byte_idx;

    int checks   = 0;
    int failures = 0;

    // Event counters maintained by the monitor only.
    int          bv_cnt = 0;
    int          wr_cnt = 0;
    int          fe_cnt = 0;
    int          proto_err = 0;
    logic [31:0] last_word = '0;
    logic [31:0] prev_word = '0;
    logic        bv_q = 1'b0, wr_q = 1'b0, fe_q = 1'b0;

    uart_rx_word #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (WIDTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .clear      (clear),
        .write      (write),
        .data_out   (data_out),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .byte_idx   (byte_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bv_q <= byte_valid;
        wr_q <= write;
        fe_q <= frame_err;
        if (byte_valid) bv_cnt <= bv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (write) begin
            wr_cnt    <= wr_cnt + 1;
            prev_word <= last_word;
            last_word <= data_out;
        end
        if ((write && !byte_valid) || (write && frame_err) ||
            (byte_valid && bv_q) || (write && wr_q) || (frame_err && fe_q))
            proto_err <= proto_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int idle_bits, input logic clr_stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx    = stop_bit;
        clear = clr_stop;
        tick(CPB);
        clear = 1'b0;
        rx    = 1'b1;
        tick(idle_bits * CPB);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
    endtask

    int bv0, wr0, fe0;

    initial begin
        // Reset state
        tick(4);
        chk("rst_write", write, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_byte_idx", byte_idx, 0);
        reset = 1'b0;
        tick(4);

        // 1: EF BE AD DE -> 0xDEADBEEF
        bv0 = bv_cnt; wr0 = wr_cnt;
        send_frame(8'hEF, 1'b1, 2, 1'b0);
        send_frame(8'hBE, 1'b1, 2, 1'b0);
        chk("s1_idx_mid", byte_idx, 2);
        chk("s1_byte_data_mid", byte_data, 8'hBE);
        send_frame(8'hAD, 1'b1, 2, 1'b0);
        send_frame(8'hDE, 1'b1, 2, 1'b0);
        chk("s1_bv_count", bv_cnt - bv0, 4);
        chk("s1_wr_count", wr_cnt - wr0, 1);
        chk("s1_word", last_word, 32'hDEADBEEF);
        chk("s1_data_out_hold", data_out, 32'hDEADBEEF);
        chk("s1_idx_wrap", byte_idx, 0);

        // 2: 5-cycle glitch, then 0x5A
        bv0 = bv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        chk("s2_glitch_bv", bv_cnt - bv0, 0);
        chk("s2_glitch_fe", fe_cnt - fe0, 0);
        chk("s2_fsm_idle", u_dut.u_byte.state, IDLE);
        send_frame(8'h5A, 1'b1, 2, 1'b0);
        chk("s2_bv_count", bv_cnt - bv0, 1);
        chk("s2_byte_data", byte_data, 8'h5A);
        chk("s2_idx", byte_idx, 1);
        pulse_clear();
        chk("s2_clear_idx", byte_idx, 0);

        // 3: 11 22, 55 with bad stop + held low, then 11 22 33 44
        wr0 = wr_cnt; fe0 = fe_cnt;
        send_frame(8'h11, 1'b1, 2, 1'b0);
        send_frame(8'h22, 1'b1, 2, 1'b0);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            tick(CPB);
        end
        rx = 1'b0;
        tick(CPB + 40);
        rx = 1'b1;
        tick(2 * CPB);
        chk("s3_fe_count", fe_cnt - fe0, 1);
        chk("s3_no_write", wr_cnt - wr0, 0);
        chk("s3_idx_dropped", byte_idx, 0);
        chk("s3_byte_data_kept", byte_data, 8'h22);
        send_frame(8'h11, 1'b1, 2, 1'b0);
        send_frame(8'h22, 1'b1, 2, 1'b0);
        send_frame(8'h33, 1'b1, 2, 1'b0);
        send_frame(8'h44, 1'b1, 2, 1'b0);
        chk("s3_wr_count", wr_cnt - wr0, 1);
        chk("s3_word", last_word, 32'h44332211);
        chk("s3_fe_total", fe_cnt - fe0, 1);

        // 4: A1 B2, clear, 01 02 03 04
        wr0 = wr_cnt;
        send_frame(8'hA1, 1'b1, 2, 1'b0);
        send_frame(8'hB2, 1'b1, 2, 1'b0);
        pulse_clear();
        chk("s4_clear_idx", byte_idx, 0);
        send_frame(8'h01, 1'b1, 2, 1'b0);
        send_frame(8'h02, 1'b1, 2, 1'b0);
        send_frame(8'h03, 1'b1, 2, 1'b0);
        send_frame(8'h04, 1'b1, 2, 1'b0);
        chk("s4_wr_count", wr_cnt - wr0, 1);
        chk("s4_word", last_word, 32'h04030201);

        // 4b: clear held across the 4th byte's stop sample wins over the write
        wr0 = wr_cnt; bv0 = bv_cnt;
        send_frame(8'h10, 1'b1, 2, 1'b0);
        send_frame(8'h20, 1'b1, 2, 1'b0);
        send_frame(8'h30, 1'b1, 2, 1'b0);
        send_frame(8'h40, 1'b1, 2, 1'b1);
        chk("s4b_no_write", wr_cnt - wr0, 0);
        chk("s4b_bv_count", bv_cnt - bv0, 4);
        chk("s4b_idx", byte_idx, 0);
        chk("s4b_data_out_hold", data_out, 32'h04030201);

        // 5: reset in the middle of the 3rd byte's data bits
        send_frame(8'hAA, 1'b1, 2, 1'b0);
        send_frame(8'hBB, 1'b1, 2, 1'b0);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(3 * CPB);
        reset = 1'b1;
        tick(3);
        chk("s5_rst_write", write, 0);
        chk("s5_rst_data_out", data_out, 0);
        chk("s5_rst_byte_valid", byte_valid, 0);
        chk("s5_rst_byte_data", byte_data, 0);
        chk("s5_rst_frame_err", frame_err, 0);
        chk("s5_rst_byte_idx", byte_idx, 0);
        reset = 1'b0;
        tick(2 * CPB);
        wr0 = wr_cnt;
        send_frame(8'h78, 1'b1, 2, 1'b0);
        send_frame(8'h56, 1'b1, 2, 1'b0);
        send_frame(8'h34, 1'b1, 2, 1'b0);
        send_frame(8'h12, 1'b1, 2, 1'b0);
        chk("s5_wr_count", wr_cnt - wr0, 1);
        chk("s5_word", last_word, 32'h12345678);

        // 6: 00..07 back to back, no idle between frames
        wr0 = wr_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(i), 1'b1, 0, 1'b0);
        end
        tick(3 * CPB);
        chk("s6_wr_count", wr_cnt - wr0, 2);
        chk("s6_word0", prev_word, 32'h03020100);
        chk("s6_word1", last_word, 32'h07060504);
        chk("s6_no_fe", fe_cnt - fe0, 0);
        chk("s6_idx", byte_idx, 0);

        // Pulse widths and write/byte_valid/frame_err relationships
        chk("protocol_errors", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
